// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - ALU operation and FSM state types shared by milano_alu_mc and milano_muldiv_iter
package milano_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_XOR    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_AND    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_AUIPC  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_opt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_mc_state_e;

  // True for the multiply/divide family that needs the iterative unit
  function automatic logic is_m_op(alu_opt_e op);
    logic m;
    case (op)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: m = 1'b1;
      default:                              m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/milano_muldiv_iter.sv
// rtl/milano_muldiv_iter.sv - XLEN-step shift-add multiplier / restoring divider working on magnitudes
module milano_muldiv_iter
  import milano_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            start_i,
  input  alu_opt_e        op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);

  // work holds {remainder, quotient} for divides and {product high, multiplier} for multiplies
  alu_opt_e          op_q, op_d;
  logic [2*XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic              bzero_q, bzero_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;

  logic              a_neg, b_neg, is_div;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] step_work, prod;
  logic [XLEN-1:0]   quo, rem;

  // Operand decode at start: signedness per op, then magnitudes and result sign
  always_comb begin
    a_neg  = 1'b0;
    b_neg  = 1'b0;
    is_div = 1'b0;
    case (op_i)
      ALU_MULH:         begin a_neg = operand_a_i[XLEN-1]; b_neg = operand_b_i[XLEN-1]; end
      ALU_MULHSU:       a_neg = operand_a_i[XLEN-1];
      ALU_DIV, ALU_REM: begin a_neg = operand_a_i[XLEN-1]; b_neg = operand_b_i[XLEN-1]; is_div = 1'b1; end
      ALU_DIVU, ALU_REMU: is_div = 1'b1;
      default: ;
    endcase
    a_mag = a_neg ? (XLEN'(0) - operand_a_i) : operand_a_i;
    b_mag = b_neg ? (XLEN'(0) - operand_b_i) : operand_b_i;
  end

  // One multiply or divide step from the current working register
  always_comb begin
    mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_shift = work_q[2*XLEN-1:XLEN-1];
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    step_work = {mul_sum, work_q[XLEN-1:1]};
    if (op_q == ALU_DIV || op_q == ALU_DIVU || op_q == ALU_REM || op_q == ALU_REMU) begin
      if (div_diff[XLEN+1]) step_work = {div_shift[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
      else                  step_work = {div_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
    end
  end

  // Final result is taken from the last step so it is ready in the cycle done_o is high
  always_comb begin
    prod     = neg_q ? ((2*XLEN)'(0) - step_work) : step_work;
    quo      = step_work[XLEN-1:0];
    rem      = step_work[2*XLEN-1:XLEN];
    result_o = prod[2*XLEN-1:XLEN];
    case (op_q)
      ALU_MUL:            result_o = prod[XLEN-1:0];
      ALU_DIV, ALU_DIVU:  result_o = bzero_q ? {XLEN{1'b1}} : (neg_q ? (XLEN'(0) - quo) : quo);
      ALU_REM, ALU_REMU:  result_o = neg_q ? (XLEN'(0) - rem) : rem;
      default: ;
    endcase
    done_o = active_q && (cnt_q == CNT_W'(XLEN-1));
  end

  // Load on start, otherwise advance one step per cycle until XLEN steps are done
  always_comb begin
    op_d     = op_q;
    work_d   = work_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    bzero_d  = bzero_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start_i) begin
      op_d     = op_i;
      cnt_d    = '0;
      active_d = 1'b1;
      bzero_d  = (operand_b_i == '0);
      neg_d    = (op_i == ALU_REM) ? a_neg : (a_neg ^ b_neg);
      work_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      opb_d    = is_div ? b_mag : a_mag;
    end else if (active_q) begin
      work_d = step_work;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(XLEN-1)) active_d = 1'b0;
    end
    if (flush_i) active_d = 1'b0;
  end

  // Iteration state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= ALU_ADD;
      work_q   <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      op_q     <= op_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/milano_alu_mc.sv
// rtl/milano_alu_mc.sv - multi-cycle ALU with valid/ready handshake; M ops enabled by MILANO_ALU_M_EXT_EN
module milano_alu_mc
  import milano_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  milano_pkg::alu_opt_e  operate_i,
  input  logic [XLEN-1:0]       operand_a_i,
  input  logic [XLEN-1:0]       operand_b_i,
  input  logic [XLEN-1:0]       instr_addr_i,
  input  logic [4:0]            rd_addr_i,
  input  logic                  rd_we_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  alu_rd_we_o,
  output logic [4:0]            alu_rd_waddr_o,
  output logic [XLEN-1:0]       alu_rd_wdata_o,
  output logic                  busy_o
);

  localparam int SHAMT_W = $clog2(XLEN);

`ifdef MILANO_ALU_M_EXT_EN
  localparam bit M_EXT_EN = 1'b1;
`else
  localparam bit M_EXT_EN = 1'b0;
`endif

  alu_mc_state_e        state_q, state_d;
  logic                 we_q, we_d;
  logic [4:0]           waddr_q, waddr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;

  logic                 accept, m_op;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      alu_res;
  logic                 alu_legal;
  logic                 iter_done;
  logic [XLEN-1:0]      iter_result;

  assign ready_o = !flush_i && ((state_q == IDLE) || ((state_q == DONE) && ready_i));
  assign accept  = valid_i && ready_o;
  assign m_op    = is_m_op(operate_i);
  assign shamt   = operand_b_i[SHAMT_W-1:0];

`ifdef MILANO_ALU_M_EXT_EN
  logic iter_start;
  assign iter_start = accept && m_op;
  assign busy_o     = (state_q == CALC);

  milano_muldiv_iter #(.XLEN(XLEN)) u_muldiv_iter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .start_i     (iter_start),
    .op_i        (operate_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .done_o      (iter_done),
    .result_o    (iter_result)
  );
`else
  assign busy_o      = 1'b0;
  assign iter_done   = 1'b0;
  assign iter_result = '0;
`endif

  // Single-cycle datapath; anything not listed here is illegal in this path
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (operate_i)
      ALU_ADD:   alu_res = operand_a_i + operand_b_i;
      ALU_SUB:   alu_res = operand_a_i - operand_b_i;
      ALU_XOR:   alu_res = operand_a_i ^ operand_b_i;
      ALU_OR:    alu_res = operand_a_i | operand_b_i;
      ALU_AND:   alu_res = operand_a_i & operand_b_i;
      ALU_SLL:   alu_res = operand_a_i << shamt;
      ALU_SRL:   alu_res = operand_a_i >> shamt;
      ALU_SRA:   alu_res = XLEN'($signed(operand_a_i) >>> shamt);
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(operand_a_i) < $signed(operand_b_i))};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (operand_a_i < operand_b_i)};
      ALU_AUIPC: alu_res = operand_b_i + instr_addr_i;
      default:   alu_legal = 1'b0;
    endcase
  end

  // Next state and output registers; an acceptance in DONE reloads directly, flush wins over all
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: ;
      CALC: if (iter_done) begin
              state_d = DONE;
              wdata_d = iter_result;
            end
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      waddr_d = rd_addr_i;
      if (M_EXT_EN && m_op) begin
        state_d = CALC;
        we_d    = rd_we_i;
      end else begin
        state_d = DONE;
        we_d    = alu_legal && rd_we_i;
        wdata_d = alu_legal ? alu_res : '0;
      end
    end
    if (flush_i) state_d = IDLE;
  end

  // State and result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign valid_o        = (state_q == DONE);
  assign alu_rd_we_o    = we_q;
  assign alu_rd_waddr_o = waddr_q;
  assign alu_rd_wdata_o = wdata_q;

endmodule

// File: doc/milano_alu_mc.md
MILANO_ALU_MC -- requirements
Module: milano_alu_mc

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width (legal values 32 or 64).
REQ-002 SHALL have derived localparam: SHAMT_W, $clog2(XLEN), shift-amount bits used from operand_b_i.
REQ-003 SHALL have the following ports, one per line:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  abandon any in-flight or held operation.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i&ready_o.
- operate_i  in  milano_pkg::alu_opt_e  operation.
- operand_a_i  in  XLEN  source A.
- operand_b_i  in  XLEN  source B / immediate.
- instr_addr_i  in  XLEN  PC, used by AUIPC.
- rd_addr_i  in  5  destination register.
- rd_we_i  in  1  destination write request.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result when valid_o&ready_i.
- alu_rd_we_o  out  1  registered write enable.
- alu_rd_waddr_o  out  5  registered destination.
- alu_rd_wdata_o  out  XLEN  registered result.
- busy_o  out  1  high while state is CALC.

Function
REQ-004 SHALL implement FSM states IDLE, CALC, DONE.
REQ-005 IDLE->DONE on acceptance of a single-cycle op; IDLE->CALC on acceptance of a MUL*/DIV*/REM* op.
REQ-006 CALC SHALL iterate exactly XLEN cycles, then enter DONE; total latency acceptance->valid_o = XLEN+1 cycles.
REQ-007 Single-cycle ops (ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU, AUIPC) SHALL give valid_o the cycle after acceptance.
REQ-008 Shifts SHALL use operand_b_i[SHAMT_W-1:0]; SRA SHALL replicate operand_a_i[XLEN-1] into all vacated bits.
REQ-009 AUIPC result SHALL be operand_b_i + instr_addr_i, modulo 2^XLEN.
REQ-010 ready_o = (state==IDLE) | (state==DONE & ready_i); back-to-back single-cycle ops SHALL sustain one result per cycle.
REQ-011 In DONE, outputs SHALL hold stable while ready_i is low; on ready_i without new acceptance, return to IDLE and drop valid_o.
REQ-012 alu_rd_we_o SHALL equal captured rd_we_i; illegal/unknown operate_i SHALL complete in one cycle with alu_rd_we_o=0, wdata=0.
REQ-013 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned.
REQ-014 Divide by zero: DIV/DIVU quotient all-ones, REM/REMU remainder = operand_a_i.
REQ-015 Signed overflow (most-negative / -1): DIV quotient = operand_a_i, REM = 0.
REQ-016 flush_i SHALL take priority over all events: next state IDLE, valid_o=0, no acceptance that cycle (ready_o=0).
REQ-017 Inputs SHALL be captured at acceptance; later changes on inputs SHALL NOT affect the in-flight result.

Reset
REQ-018 On rst_ni low, asynchronously: state=IDLE, valid_o=0, busy_o=0, alu_rd_we_o=0, alu_rd_waddr_o=0, alu_rd_wdata_o=0, iteration counter=0.
REQ-019 Reset during CALC SHALL discard the operation; no result is ever presented for it.

Configuration
REQ-020 Macro MILANO_ALU_M_EXT_EN defined: MUL*/DIV*/REM* supported per REQ-006, REQ-013 to REQ-015.
REQ-021 MILANO_ALU_M_EXT_EN undefined: iterative sub-module not instantiated, CALC unreachable, M ops treated as illegal per REQ-012, busy_o tied 0.

Structure
REQ-022 milano_pkg SHALL hold alu_opt_e extended with ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, and alu_mc_state_e {IDLE, CALC, DONE}.
REQ-023 Iterative shift-add multiplier / restoring divider SHALL be sub-module milano_muldiv_iter (start, op, operands in; done, result out), parametrised by XLEN.

Verification
REQ-024 ADD 0xFFFFFFFF+1, rd=5, we=1, ready_i=1 -> next cycle valid_o=1, wdata=0x0, waddr=5, we=1.
REQ-025 SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL same -> 0x00000001.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 33 cycles; REM 7/0 -> 7; DIVU 7/0 -> 0xFFFFFFFF.
REQ-027 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL -> 0x00000001; busy_o high exactly 32 cycles.
REQ-028 Result presented with ready_i=0 for 5 cycles -> wdata/waddr/we stable, ready_o=0; ready_i=1 -> handshake completes, next op accepted same cycle.
REQ-029 flush_i asserted mid-DIV (cycle 10), then rst_ni pulse mid-MUL -> no valid_o for either, state IDLE, all outputs 0 after reset.
